// File: rtl/nco_pkg.sv
// Shared constants for the multi-channel NCO: waveform select codes and default widths.
package nco_pkg;

  localparam logic [1:0] WAVE_OFF    = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_SAW    = 2'b10;
  localparam logic [1:0] WAVE_TRI    = 2'b11;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_PHASE_W = 16;
  localparam int DEF_FTW_W   = 16;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_AMP_W   = 6;

  // enable_in to valid_out delay, in clock edges
  localparam int VALID_DEPTH = 3;

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: config registers, phase accumulator, registered wave gen and amplitude scale.
// Optional per-channel phase offset is compiled in with NCO_PHASE_OFFSET_EN.
module nco_channel
  import nco_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int FTW_W   = DEF_FTW_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int AMP_W   = DEF_AMP_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_sync,
  input  logic                    i_we,
  input  logic [FTW_W-1:0]        i_ftw,
  input  logic [1:0]              i_wavesel,
  input  logic [AMP_W-1:0]        i_amp,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0]      i_poff,
`endif
  output logic signed [OUT_W-1:0] o_wave
);

  localparam int PROD_W = OUT_W + AMP_W + 1;

  logic [FTW_W-1:0]        r_ftw;
  logic [1:0]              r_wavesel;
  logic [AMP_W-1:0]        r_amp;
  logic [PHASE_W-1:0]      r_phase;
  logic signed [OUT_W-1:0] r_wave;
  logic signed [OUT_W-1:0] r_out;

  logic [PHASE_W-1:0]      w_poff;
  logic [PHASE_W-1:0]      w_ftw_ext;
  logic [PHASE_W-1:0]      w_gen_phase;
  logic [PHASE_W-1:0]      w_gen_phase_unused;
  logic [OUT_W-1:0]        w_tri;
  logic signed [OUT_W-1:0] w_wave_nxt;
  logic signed [PROD_W-1:0] w_wave_ext;
  logic signed [PROD_W-1:0] w_amp_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0]       w_prod_unused;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ftw     <= '0;
      r_wavesel <= WAVE_OFF;
      r_amp     <= '0;
    end else if (i_we) begin
      r_ftw     <= i_ftw;
      r_wavesel <= i_wavesel;
      r_amp     <= i_amp;
    end
  end

`ifdef NCO_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] r_poff;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_poff <= '0;
    else if (i_we) r_poff <= i_poff;
  end

  assign w_poff = r_poff;
`else
  assign w_poff = '0;
`endif

  assign w_ftw_ext = PHASE_W'(r_ftw);

  // Disable dominates sync; both park the accumulator at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_phase <= '0;
    else if (!i_enable || i_sync)  r_phase <= '0;
    else                           r_phase <= r_phase + w_ftw_ext;
  end

  assign w_gen_phase        = r_phase + w_poff;
  assign w_gen_phase_unused = w_gen_phase;

  always_comb begin
    w_tri = w_gen_phase[PHASE_W-2 -: OUT_W];
    if (w_gen_phase[PHASE_W-1]) w_tri = ~w_tri;
    w_wave_nxt = '0;
    case (r_wavesel)
      WAVE_OFF:    w_wave_nxt = '0;
      WAVE_SQUARE: w_wave_nxt = w_gen_phase[PHASE_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                       : {1'b0, {(OUT_W-1){1'b1}}};
      WAVE_SAW:    w_wave_nxt = {~w_gen_phase[PHASE_W-1], w_gen_phase[PHASE_W-2 -: OUT_W-1]};
      WAVE_TRI:    w_wave_nxt = {~w_tri[OUT_W-1], w_tri[OUT_W-2:0]};
      default:     w_wave_nxt = '0;
    endcase
  end

  // Unsigned amp as a non-negative signed operand; product can never overflow PROD_W.
  assign w_wave_ext    = {{(AMP_W+1){r_wave[OUT_W-1]}}, r_wave};
  assign w_amp_ext     = {{(OUT_W+1){1'b0}}, r_amp};
  assign w_prod        = w_wave_ext * w_amp_ext;
  assign w_prod_unused = w_prod;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wave <= '0;
      r_out  <= '0;
    end else begin
      r_wave <= w_wave_nxt;
      r_out  <= w_prod[AMP_W +: OUT_W];
    end
  end

  assign o_wave = r_out;

endmodule

// File: rtl/nco_multi_ch.sv
// Multi-channel NCO top: config write decode, shared sync/enable, valid delay line, output packing.
// Build option NCO_PHASE_OFFSET_EN adds the cfg_poff_in per-channel phase offset port.
module nco_multi_ch
  import nco_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int FTW_W   = DEF_FTW_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int AMP_W   = DEF_AMP_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable_in,
  input  logic                     sync_in,
  input  logic                     cfg_we_in,
  input  logic [CH_W-1:0]          cfg_ch_in,
  input  logic [FTW_W-1:0]         cfg_ftw_in,
  input  logic [1:0]               cfg_wavesel_in,
  input  logic [AMP_W-1:0]         cfg_amp_in,
`ifdef NCO_PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0]       cfg_poff_in,
`endif
  output logic [NUM_CH*OUT_W-1:0]  wave_out,
  output logic                     valid_out
);

  logic [VALID_DEPTH-1:0] r_valid_sr;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic w_we;

    // Indices at or beyond NUM_CH match no channel, so such writes are dropped.
    assign w_we = cfg_we_in && (cfg_ch_in == CH_W'(k));

    nco_channel #(
      .PHASE_W (PHASE_W),
      .FTW_W   (FTW_W),
      .OUT_W   (OUT_W),
      .AMP_W   (AMP_W)
    ) u_ch (
      .i_clk     (clk_in),
      .i_rst     (rst_in),
      .i_enable  (enable_in),
      .i_sync    (sync_in),
      .i_we      (w_we),
      .i_ftw     (cfg_ftw_in),
      .i_wavesel (cfg_wavesel_in),
      .i_amp     (cfg_amp_in),
`ifdef NCO_PHASE_OFFSET_EN
      .i_poff    (cfg_poff_in),
`endif
      .o_wave    (wave_out[k*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_valid_sr <= '0;
    else        r_valid_sr <= {r_valid_sr[VALID_DEPTH-2:0], enable_in};
  end

  assign valid_out = r_valid_sr[VALID_DEPTH-1];

endmodule

// File: tb/tb_nco_multi_ch.sv
// Directed bench for nco_multi_ch: a 4-channel and a 3-channel instance share all stimulus.
// Rows of {inputs, expected outputs} are applied one clock edge each.
module tb_nco_multi_ch;
  import nco_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        enable_in = 1'b0;
  logic        sync_in = 1'b0;
  logic        cfg_we_in = 1'b0;
  logic [1:0]  cfg_ch_in = '0;
  logic [15:0] cfg_ftw_in = '0;
  logic [1:0]  cfg_wavesel_in = '0;
  logic [5:0]  cfg_amp_in = '0;
`ifdef NCO_PHASE_OFFSET_EN
  logic [15:0] cfg_poff_in = '0;
`endif
  logic [31:0] wave_out;
  logic        valid_out;
  logic [23:0] wave3;
  logic        valid3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        we;
    logic        sync;
    logic [1:0]  ch;
    logic [15:0] ftw;
    logic [1:0]  ws;
    logic [5:0]  amp;
    logic        ev;
    int          e0, e1, e2, e3;
  } vec_t;

  vec_t vq[$];

  // Saw ramp, amp=63, indexed by top phase nibble
  int saw63[16] = '{-126, -111, -95, -79, -63, -48, -32, -16, 0, 15, 31, 47, 63, 78, 94, 110};
  int tri63[4]  = '{-126, 0, 125, -1};

  nco_multi_ch dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .sync_in        (sync_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_ch_in      (cfg_ch_in),
    .cfg_ftw_in     (cfg_ftw_in),
    .cfg_wavesel_in (cfg_wavesel_in),
    .cfg_amp_in     (cfg_amp_in),
`ifdef NCO_PHASE_OFFSET_EN
    .cfg_poff_in    (cfg_poff_in),
`endif
    .wave_out       (wave_out),
    .valid_out      (valid_out)
  );

  nco_multi_ch #(.NUM_CH(3)) dut3 (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .sync_in        (sync_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_ch_in      (cfg_ch_in),
    .cfg_ftw_in     (cfg_ftw_in),
    .cfg_wavesel_in (cfg_wavesel_in),
    .cfg_amp_in     (cfg_amp_in),
`ifdef NCO_PHASE_OFFSET_EN
    .cfg_poff_in    (cfg_poff_in),
`endif
    .wave_out       (wave3),
    .valid_out      (valid3)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic we, input logic [1:0] ch, input logic [15:0] ftw,
                     input logic [1:0] ws, input logic [5:0] amp, input logic sync, input logic ev,
                     input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.en = en; v.we = we; v.sync = sync; v.ch = ch; v.ftw = ftw; v.ws = ws; v.amp = amp;
    v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vq.push_back(v);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] ftw, input logic [1:0] ws,
                    input logic [5:0] amp, input logic sync, input logic ev,
                    input int e0, input int e1, input int e2, input int e3);
    add(1'b1, 1'b1, ch, ftw, ws, amp, sync, ev, e0, e1, e2, e3);
  endtask

  task automatic row(input logic en, input logic ev,
                     input int e0, input int e1, input int e2, input int e3);
    add(en, 1'b0, 2'd0, 16'h0, WAVE_OFF, 6'd0, 1'b0, ev, e0, e1, e2, e3);
  endtask

  task automatic quiet_inputs();
    enable_in = 1'b0; sync_in = 1'b0; cfg_we_in = 1'b0; cfg_ch_in = '0;
    cfg_ftw_in = '0; cfg_wavesel_in = '0; cfg_amp_in = '0;
  endtask

  // Asserts reset between edges and checks outputs clear without waiting for a clock.
  task automatic do_reset(input string tag);
    quiet_inputs();
    rst_in = 1'b1;
    #2;
    chk({tag, " async wave"}, int'(wave_out), 0);
    chk({tag, " async valid"}, int'(valid_out), 0);
    chk({tag, " async wave3"}, int'(wave3), 0);
    chk({tag, " async valid3"}, int'(valid3), 0);
    @(posedge clk_in); #1;
    chk({tag, " held wave"}, int'(wave_out), 0);
    rst_in = 1'b0;
  endtask

  task automatic run_table(input string tag);
    int e[4];
    for (int i = 0; i < vq.size(); i++) begin
      enable_in      = vq[i].en;
      cfg_we_in      = vq[i].we;
      sync_in        = vq[i].sync;
      cfg_ch_in      = vq[i].ch;
      cfg_ftw_in     = vq[i].ftw;
      cfg_wavesel_in = vq[i].ws;
      cfg_amp_in     = vq[i].amp;
      @(posedge clk_in); #1;
      e = '{vq[i].e0, vq[i].e1, vq[i].e2, vq[i].e3};
      chk($sformatf("%s r%0d valid", tag, i), int'(valid_out), int'(vq[i].ev));
      chk($sformatf("%s r%0d valid3", tag, i), int'(valid3), int'(vq[i].ev));
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s r%0d ch%0d", tag, i, k), int'($signed(wave_out[k*8 +: 8])), e[k]);
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s r%0d dut3 ch%0d", tag, i, k), int'($signed(wave3[k*8 +: 8])), e[k]);
    end
    vq.delete();
    cfg_we_in = 1'b0;
    sync_in   = 1'b0;
  endtask

  initial begin
    #1;
    do_reset("init");

    // Saw on ch0 through a full phase wrap
    wr(2'd0, 16'h1000, WAVE_SAW, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    row(1'b1, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n <= 16; n++) row(1'b1, 1'b1, saw63[n % 16], 0, 0, 0);
    run_table("saw");

    // Square at Nyquist on ch1
    do_reset("rst2");
    wr(2'd1, 16'h8000, WAVE_SQUARE, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    row(1'b1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) row(1'b1, 1'b1, 0, (i % 2 == 0) ? 125 : -126, 0, 0);
    run_table("square");

    // Triangle on ch2, then amplitude dropped to zero
    do_reset("rst3");
    wr(2'd2, 16'h4000, WAVE_TRI, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    row(1'b1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) row(1'b1, 1'b1, 0, 0, tri63[i % 4], 0);
    wr(2'd2, 16'h4000, WAVE_TRI, 6'd0, 1'b0, 1'b1, 0, 0, 125, 0);
    for (int i = 0; i < 3; i++) row(1'b1, 1'b1, 0, 0, 0, 0);
    run_table("tri");

    // Sync together with a write to ch3: both phases zeroed, ch3 then steps by the new word
    do_reset("rst4");
    wr(2'd0, 16'h1000, WAVE_SAW, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    wr(2'd3, 16'h0800, WAVE_SAW, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    row(1'b1, 1'b1, -126, 0, 0, 0);
    row(1'b1, 1'b1, -111, 0, 0, -126);
    wr(2'd3, 16'h2300, WAVE_SAW, 6'd63, 1'b1, 1'b1, -95, 0, 0, -119);
    row(1'b1, 1'b1, -79, 0, 0, -111);
    row(1'b1, 1'b1, -126, 0, 0, -126);
    row(1'b1, 1'b1, -111, 0, 0, -92);
    row(1'b1, 1'b1, -95, 0, 0, -58);
    row(1'b1, 1'b1, -79, 0, 0, -23);
    run_table("sync");

    // Negative-going words wrap downward; ch3 write is out of range for the 3-channel DUT
    do_reset("rst5");
    wr(2'd0, 16'hFFFF, WAVE_SAW, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    wr(2'd1, 16'hF000, WAVE_SAW, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    wr(2'd3, 16'h1000, WAVE_SQUARE, 6'd63, 1'b0, 1'b1, -126, 0, 0, 0);
    row(1'b1, 1'b1, 125, -126, 0, 0);
    row(1'b1, 1'b1, 125, 110, 0, 125);
    row(1'b1, 1'b1, 125, 94, 0, 125);
    row(1'b1, 1'b1, 125, 78, 0, 125);
    run_table("wrap");

    // Reset lands mid-run, then enable drops and valid trails it by three edges
    do_reset("midrun");
    wr(2'd0, 16'h1000, WAVE_SAW, 6'd63, 1'b0, 1'b0, 0, 0, 0, 0);
    row(1'b1, 1'b0, 0, 0, 0, 0);
    row(1'b1, 1'b1, -126, 0, 0, 0);
    row(1'b1, 1'b1, -111, 0, 0, 0);
    row(1'b1, 1'b1, -95, 0, 0, 0);
    row(1'b0, 1'b1, -79, 0, 0, 0);
    row(1'b0, 1'b1, -63, 0, 0, 0);
    row(1'b0, 1'b0, -126, 0, 0, 0);
    row(1'b0, 1'b0, -126, 0, 0, 0);
    row(1'b0, 1'b0, -126, 0, 0, 0);
    run_table("disable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_multi_ch.md
Name: nco_multi_ch

Overview:
- Parametrised multi-channel numerically controlled oscillator; successor to the single-channel 6-bit NCO/DDS path.
- Provides NUM_CH independent channels, each with:
  - a modulo-2^PHASE_W phase accumulator with true wrap-around,
  - per-channel frequency word, waveform select and amplitude registers loaded through a write port.
- Global phase-sync strobe for phase alignment.
- Registered wave-generation and amplitude-scaling pipeline.
- Sits between the pin-level wrapper and the output pins; drives a packed bus of signed samples.

Parameters:
- NUM_CH, 4, number of channels (≥1)
- PHASE_W, 16, phase accumulator width
- FTW_W, 16, frequency tuning word width (≤ PHASE_W, zero-extended)
- OUT_W, 8, signed sample width (≤ PHASE_W−1)
- AMP_W, 6, unsigned amplitude width
- CH_W, max(1,$clog2(NUM_CH)), channel index width (derived)

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-high
- enable_in  in  1  run enable; low clears phases
- sync_in  in  1  phase-sync strobe, all channels
- cfg_we_in  in  1  config write strobe
- cfg_ch_in  in  CH_W  target channel
- cfg_ftw_in  in  FTW_W  frequency word
- cfg_wavesel_in  in  2  00 off, 01 square, 10 sawtooth, 11 triangle
- cfg_amp_in  in  AMP_W  amplitude
- wave_out  out  NUM_CH*OUT_W  signed samples; channel k at [k*OUT_W +: OUT_W]
- valid_out  out  1  pipeline output valid

Behaviour:
Reset:
- rst_in high clears immediately, independent of clk_in: all FTW, wavesel, amp, phase, pipeline registers, wave_out and valid_out go to 0.
- Reset may assert mid-operation.

Config writes:
- When cfg_we_in=1 at a clock edge, channel cfg_ch_in loads ftw, wavesel and amp together.
- cfg_ch_in ≥ NUM_CH: write ignored.
- New values take effect from the following edge.

Phase update, per channel per edge, in priority order:
1. rst_in.
2. enable_in=0 → phase <= 0.
3. sync_in=1 → phase <= 0.
4. Otherwise phase <= (phase + zero-extended ftw) mod 2^PHASE_W. Natural wrap, no saturation, no direction reversal.

Simultaneous events:
- Write and sync in the same cycle: config is stored and phase loads 0; the first increment uses the new FTW.

Stage 1 (registered wave gen, from phase P, MSB m=P[PHASE_W−1]):
- off: 0.
- square: m=0 → +(2^(OUT_W−1)−1), m=1 → −2^(OUT_W−1).
- sawtooth: P[PHASE_W−1 -: OUT_W] with MSB inverted (offset-binary to two's complement).
- triangle: t = P[PHASE_W−2 -: OUT_W]; if m=1 then t=~t; output t with MSB inverted.
- Wavesel and amp are the values current at the time of generation; no per-stage alignment.

Stage 2 (registered scale):
- prod = wave × {1'b0, amp}, signed, width OUT_W+AMP_W+1.
- out = (prod >>> AMP_W) truncated to OUT_W bits.
- Floor rounding. Cannot overflow because amp ≤ 2^AMP_W−1.

Latency and valid:
- Phase register to wave_out latency is 2 edges.
- valid_out equals enable_in delayed by 3 edges (a 3-stage shift register).
- enable_in low: valid_out falls 3 edges later; wave_out reflects zero phase thereafter.
- enable_in, sync_in and cfg inputs are synchronous to clk_in; no handshake back-pressure.

Optional Feature:
Macro NCO_PHASE_OFFSET_EN.
- Defined:
  - Adds port cfg_poff_in, in, PHASE_W, per-channel phase offset, loaded with the other fields on cfg_we_in; reset value 0.
  - Stage 1 uses (phase + poff) mod 2^PHASE_W.
  - Latency unchanged.
- Undefined: port absent; offset is constant 0. Behaviour is identical to a defined build with all offsets 0.

Decomposition:
- Package nco_pkg:
  - wavesel localparams WAVE_OFF=2'b00, WAVE_SQUARE=2'b01, WAVE_SAW=2'b10, WAVE_TRI=2'b11.
  - Default width constants.
- Sub-module nco_channel: config registers, accumulator and the 2-stage pipeline for one channel. Instantiated NUM_CH times via generate.
- Top-level owns: write decode, sync, valid shift register and output packing.

Test Plan (PHASE_W=16, OUT_W=8, AMP_W=6, NUM_CH=4):
1. Reset, enable, write ch0 ftw=0x1000, saw, amp=63 → phase 0,0x1000,…,0xF000,0x0000 (wrap at edge 16). wave_out[7:0] starts −126, −111, …; valid_out high 3 edges after enable.
2. ch1 ftw=0x8000, square, amp=63 → ch1 output alternates 125, −126 every cycle.
3. ch2 ftw=0x4000, triangle, amp=63 → stage-1 sequence −128, 0, 127, −1 repeating; scaled −126, 0, 125, −1. Setting amp=0 gives constant 0.
4. ch0 ftw=0x1000, ch3 ftw=0x2300, both saw amp=63; pulse sync_in one cycle together with a write to ch3 → both phases 0 next edge. 2 edges later outputs equal (−126). ch3 then advances by 0x2300.
5. ftw=0xFFFF → phase 0, 0xFFFF, 0xFFFE (wrap acts as decrement). Write with cfg_ch_in out of range for NUM_CH=3 → no register changes.
6. Assert rst_in asynchronously mid-run → wave_out=0 and valid_out=0 before the next edge. enable_in low → phases 0; valid_out low after 3 edges.
